c3po_out_pkt_chk: RTL and testbench

Downstream consumer of the c3po 32-byte output beat stream. Reassembles beats into packets and checks framing. Emits one report record per packet (byte length, XOR checksum, error flags) through a small valid/ready report FIFO, plus free-running statistics counters. The beat input has no backpressure: every valid beat is accepted the cycle it is presented.

---
 rtl/c3po_pkg.sv | 45 ++++
 rtl/c3po_out_pkt_chk_if.sv | 31 +++
 rtl/c3po_rpt_fifo.sv | 66 ++++++
 rtl/c3po_out_pkt_chk.sv | 181 ++++++++++++++++++
 tb/tb_c3po_out_pkt_chk.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/c3po_pkg.sv
// c3po_pkg
//   Shared constants and types for the c3po output-side packet checker.
//   - C3PO_OUT_BYTES : bytes per output beat
//   - ERR_*          : bit positions inside the 4-bit report error field
//   - state_e        : packet-reassembly FSM states
//   - rpt_t          : report record layout {len, csum, err} at the default length width
//   - xor_fold()     : XOR of the low nbytes bytes of a beat
package c3po_pkg;

    localparam int C3PO_OUT_BYTES = 32;
    localparam int BEAT_W         = C3PO_OUT_BYTES * 8;

    localparam int ERR_W          = 4;
    localparam int ERR_SOP_IN_PKT = 0;
    localparam int ERR_VBC_BAD    = 1;
    localparam int ERR_SHORT_BEAT = 2;
    localparam int ERR_LEN_SAT    = 3;

    localparam int RPT_LEN_W      = 16;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } state_e;

    // The report FIFO carries this same layout flattened, with the length
    // field sized by the checker's LEN_W_P.
    typedef struct packed {
        logic [RPT_LEN_W-1:0] len;
        logic [7:0]           csum;
        logic [ERR_W-1:0]     err;
    } rpt_t;

    // Bytes at index >= nbytes are masked out of the fold.
    function automatic logic [7:0] xor_fold(input logic [BEAT_W-1:0] data,
                                            input logic [7:0]        nbytes);
        logic [7:0] acc;
        acc = '0;
        for (int k = 0; k < C3PO_OUT_BYTES; k++) begin
            if (k < int'(nbytes)) acc = acc ^ data[8*k +: 8];
        end
        return acc;
    endfunction

endpackage

// File: rtl/c3po_out_pkt_chk_if.sv
// c3po_out_pkt_chk_if
//   Beat input and report output bundle of the c3po output packet checker.
//   Beat side : sig_i_sop, sig_i_eop, sig_i_val, sig_i_vbc[7:0], sig_i_data[255:0]
//   Report    : sig_rpt_val, sig_rpt_rdy, sig_rpt_len, sig_rpt_csum[7:0], sig_rpt_err[3:0]
//   master : beat producer / report consumer
//   slave  : the checker
interface c3po_out_pkt_chk_if #(
    parameter int LEN_W_P = 16
);
    logic               sig_i_sop;
    logic               sig_i_eop;
    logic               sig_i_val;
    logic [7:0]         sig_i_vbc;
    logic [255:0]       sig_i_data;

    logic               sig_rpt_val;
    logic               sig_rpt_rdy;
    logic [LEN_W_P-1:0] sig_rpt_len;
    logic [7:0]         sig_rpt_csum;
    logic [3:0]         sig_rpt_err;

    modport master (
        output sig_i_sop, sig_i_eop, sig_i_val, sig_i_vbc, sig_i_data, sig_rpt_rdy,
        input  sig_rpt_val, sig_rpt_len, sig_rpt_csum, sig_rpt_err
    );

    modport slave (
        input  sig_i_sop, sig_i_eop, sig_i_val, sig_i_vbc, sig_i_data, sig_rpt_rdy,
        output sig_rpt_val, sig_rpt_len, sig_rpt_csum, sig_rpt_err
    );
endinterface

// File: rtl/c3po_rpt_fifo.sv
// c3po_rpt_fifo
//   Synchronous fall-through FIFO for report records.
//   sig_clock/sig_reset : clock, asynchronous active-high reset
//   push, push_data     : write request; accepted when not full, or when full
//                         and a pop happens in the same cycle
//   pop                 : remove head (ignored when empty)
//   full, empty         : occupancy flags
//   head                : current head record, all zeros when empty
module c3po_rpt_fifo #(
    parameter int WIDTH_P = 28,
    parameter int DEPTH_P = 4
) (
    input  logic               sig_clock,
    input  logic               sig_reset,
    input  logic               push,
    input  logic [WIDTH_P-1:0] push_data,
    input  logic               pop,
    output logic               full,
    output logic               empty,
    output logic [WIDTH_P-1:0] head
);
    localparam int AW = $clog2(DEPTH_P);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]        wr_q, wr_d;
    logic [AW:0]        rd_q, rd_d;
    logic [WIDTH_P-1:0] mem_q [DEPTH_P];
    logic               push_ok;
    logic               pop_ok;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Gate the head so an empty FIFO shows zeros instead of stale storage.
    assign head = empty ? '0 : mem_q[rd_q[AW-1:0]];

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push_ok) wr_d = wr_q + (AW+1)'(1);
        if (pop_ok)  rd_d = rd_q + (AW+1)'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge sig_clock or posedge sig_reset) begin
        if (sig_reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide
    // which entries are valid, and an unreset array maps onto plain RAM.
    always_ff @(posedge sig_clock) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/c3po_out_pkt_chk.sv
// c3po_out_pkt_chk
//   Reassembles c3po 32-byte output beats into packets, checks framing and
//   emits one {len, csum, err} record per packet through a report FIFO.
//   sig_clock, sig_reset : clock, asynchronous active-high reset
//   bus (slave)          : beat input (no backpressure) and report valid/ready
//   sig_pkt_cnt          : records created (pushed or dropped)
//   sig_err_cnt          : records with nonzero err, plus aborted packets
//   sig_orphan_cnt       : beats discarded outside a packet
//   sig_drop_cnt         : records lost to a full FIFO
//   sig_idle             : FSM idle and FIFO empty
module c3po_out_pkt_chk
    import c3po_pkg::*;
#(
    parameter int CNT_SIZE_P   = 8,
    parameter int LEN_W_P      = 16,
    parameter int FIFO_DEPTH_P = 4
) (
    input  logic                  sig_clock,
    input  logic                  sig_reset,
    c3po_out_pkt_chk_if.slave     bus,
    output logic [CNT_SIZE_P-1:0] sig_pkt_cnt,
    output logic [CNT_SIZE_P-1:0] sig_err_cnt,
    output logic [CNT_SIZE_P-1:0] sig_orphan_cnt,
    output logic [CNT_SIZE_P-1:0] sig_drop_cnt,
    output logic                  sig_idle
);
    localparam int                 REC_W   = LEN_W_P + 8 + ERR_W;
    localparam logic [LEN_W_P-1:0] LEN_MAX = '1;
    localparam logic [7:0]         FULL_VBC = 8'(C3PO_OUT_BYTES);

    state_e                state_q, state_d;
    logic [LEN_W_P-1:0]    len_q, len_d;
    logic [7:0]            csum_q, csum_d;
    logic [ERR_W-1:0]      err_q, err_d;
    logic [CNT_SIZE_P-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_SIZE_P-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_SIZE_P-1:0] orphan_cnt_q, orphan_cnt_d;
    logic [CNT_SIZE_P-1:0] drop_cnt_q, drop_cnt_d;

    // Per-beat contribution
    logic                  vbc_ok;
    logic [LEN_W_P-1:0]    beat_len;
    logic [7:0]            beat_csum;

    // Packet the current beat joins (fresh on open/abort, else accumulated)
    logic                  take;
    logic [LEN_W_P-1:0]    base_len;
    logic [7:0]            base_csum;
    logic [ERR_W-1:0]      base_err;
    logic [LEN_W_P:0]      sum;
    logic [LEN_W_P-1:0]    acc_len;
    logic [7:0]            acc_csum;
    logic [ERR_W-1:0]      acc_err;
    logic [1:0]            err_inc;

    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [REC_W-1:0]      head_rec;

    assign vbc_ok    = (bus.sig_i_vbc != 8'd0) && (bus.sig_i_vbc <= FULL_VBC);
    assign beat_len  = vbc_ok ? LEN_W_P'(bus.sig_i_vbc) : '0;
    assign beat_csum = xor_fold(bus.sig_i_data, vbc_ok ? bus.sig_i_vbc : 8'd0);

    assign pop             = bus.sig_rpt_val && bus.sig_rpt_rdy;
    assign bus.sig_rpt_val = !empty;
    assign {bus.sig_rpt_len, bus.sig_rpt_csum, bus.sig_rpt_err} = head_rec;

    assign sig_idle       = (state_q == ST_IDLE) && empty;
    assign sig_pkt_cnt    = pkt_cnt_q;
    assign sig_err_cnt    = err_cnt_q;
    assign sig_orphan_cnt = orphan_cnt_q;
    assign sig_drop_cnt   = drop_cnt_q;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        csum_d       = csum_q;
        err_d        = err_q;
        pkt_cnt_d    = pkt_cnt_q;
        orphan_cnt_d = orphan_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        err_inc      = 2'd0;
        push         = 1'b0;
        take         = 1'b0;
        base_len     = len_q;
        base_csum    = csum_q;
        base_err     = err_q;

        if (bus.sig_i_val) begin
            if (state_q == ST_IDLE) begin
                if (bus.sig_i_sop) begin
                    take      = 1'b1;
                    base_len  = '0;
                    base_csum = '0;
                    base_err  = '0;
                end else begin
                    orphan_cnt_d = orphan_cnt_q + CNT_SIZE_P'(1);
                end
            end else begin
                take = 1'b1;
                if (bus.sig_i_sop) begin
                    // Abort: the open packet vanishes without a record and the
                    // new one starts from this beat flagged.
                    err_inc                  = err_inc + 2'd1;
                    base_len                 = '0;
                    base_csum                = '0;
                    base_err                 = '0;
                    base_err[ERR_SOP_IN_PKT] = 1'b1;
                end
            end
        end

        // One extra sum bit detects overflow; length clamps, csum keeps going.
        sum      = {1'b0, base_len} + {1'b0, beat_len};
        acc_len  = sum[LEN_W_P] ? LEN_MAX : sum[LEN_W_P-1:0];
        acc_csum = base_csum ^ beat_csum;
        acc_err  = base_err;
        if (!vbc_ok)                                     acc_err[ERR_VBC_BAD]    = 1'b1;
        if (!bus.sig_i_eop && bus.sig_i_vbc != FULL_VBC) acc_err[ERR_SHORT_BEAT] = 1'b1;
        if (sum[LEN_W_P])                                acc_err[ERR_LEN_SAT]    = 1'b1;

        if (take) begin
            if (bus.sig_i_eop) begin
                push      = 1'b1;
                state_d   = ST_IDLE;
                len_d     = '0;
                csum_d    = '0;
                err_d     = '0;
                pkt_cnt_d = pkt_cnt_q + CNT_SIZE_P'(1);
                if (acc_err != '0) err_inc = err_inc + 2'd1;
                if (full && !pop)  drop_cnt_d = drop_cnt_q + CNT_SIZE_P'(1);
            end else begin
                state_d = ST_IN_PKT;
                len_d   = acc_len;
                csum_d  = acc_csum;
                err_d   = acc_err;
            end
        end

        err_cnt_d = err_cnt_q + CNT_SIZE_P'(err_inc);
    end

    always_ff @(posedge sig_clock or posedge sig_reset) begin
        if (sig_reset) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            csum_q       <= '0;
            err_q        <= '0;
            pkt_cnt_q    <= '0;
            err_cnt_q    <= '0;
            orphan_cnt_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            csum_q       <= csum_d;
            err_q        <= err_d;
            pkt_cnt_q    <= pkt_cnt_d;
            err_cnt_q    <= err_cnt_d;
            orphan_cnt_q <= orphan_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    c3po_rpt_fifo #(
        .WIDTH_P (REC_W),
        .DEPTH_P (FIFO_DEPTH_P)
    ) u_rpt_fifo (
        .sig_clock (sig_clock),
        .sig_reset (sig_reset),
        .push      (push),
        .push_data ({acc_len, acc_csum, acc_err}),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .head      (head_rec)
    );

endmodule

// File: tb/tb_c3po_out_pkt_chk.sv
// tb_c3po_out_pkt_chk
//   Self-checking bench for c3po_out_pkt_chk: directed scenarios followed by
//   randomized beats, all compared against a packet-level reference model.
module tb_c3po_out_pkt_chk;
    import c3po_pkg::*;

    localparam int CNT_W   = 8;
    localparam int LEN_W   = 16;
    localparam int DEPTH   = 4;
    localparam int LEN_LIM = (1 << LEN_W) - 1;

    logic             sig_clock = 1'b0;
    logic             sig_reset;
    logic [CNT_W-1:0] sig_pkt_cnt;
    logic [CNT_W-1:0] sig_err_cnt;
    logic [CNT_W-1:0] sig_orphan_cnt;
    logic [CNT_W-1:0] sig_drop_cnt;
    logic             sig_idle;

    c3po_out_pkt_chk_if #(.LEN_W_P(LEN_W)) bus ();

    c3po_out_pkt_chk #(
        .CNT_SIZE_P   (CNT_W),
        .LEN_W_P      (LEN_W),
        .FIFO_DEPTH_P (DEPTH)
    ) dut (
        .sig_clock      (sig_clock),
        .sig_reset      (sig_reset),
        .bus            (bus),
        .sig_pkt_cnt    (sig_pkt_cnt),
        .sig_err_cnt    (sig_err_cnt),
        .sig_orphan_cnt (sig_orphan_cnt),
        .sig_drop_cnt   (sig_drop_cnt),
        .sig_idle       (sig_idle)
    );

    always #5 sig_clock = ~sig_clock;

    int total = 0;
    int bad   = 0;

    // Reference model: open packet as an unbounded byte total, report queue.
    rpt_t       mq[$];
    bit         m_open;
    int         m_total;
    logic [7:0] m_csum;
    logic [3:0] m_err;
    int         m_pkt, m_errc, m_orph, m_drop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_open = 1'b0; m_total = 0; m_csum = '0; m_err = '0;
        m_pkt = 0; m_errc = 0; m_orph = 0; m_drop = 0;
    endtask

    task automatic model_start();
        m_total = 0; m_csum = '0; m_err = '0;
    endtask

    task automatic model_beat(input bit val, input bit sop, input bit eop,
                              input logic [7:0] vbc, input logic [255:0] data, input bit rdy);
        bit   joins;
        rpt_t r;
        joins = 1'b0;
        if (mq.size() > 0 && rdy) void'(mq.pop_front());
        if (val) begin
            if (!m_open) begin
                if (sop) begin joins = 1'b1; model_start(); end
                else m_orph++;
            end else begin
                joins = 1'b1;
                if (sop) begin m_errc++; model_start(); m_err[0] = 1'b1; end
            end
            if (joins) begin
                if (vbc >= 1 && vbc <= 32) begin
                    m_total += int'(vbc);
                    for (int k = 0; k < int'(vbc); k++) m_csum ^= data[8*k +: 8];
                end else begin
                    m_err[1] = 1'b1;
                end
                if (!eop && vbc != 8'd32) m_err[2] = 1'b1;
                if (eop) begin
                    if (m_total > LEN_LIM) m_err[3] = 1'b1;
                    r.len  = (m_total > LEN_LIM) ? LEN_W'(LEN_LIM) : LEN_W'(m_total);
                    r.csum = m_csum;
                    r.err  = m_err;
                    m_pkt++;
                    if (m_err != 4'd0) m_errc++;
                    if (mq.size() < DEPTH) mq.push_back(r);
                    else m_drop++;
                    m_open = 1'b0;
                end else begin
                    m_open = 1'b1;
                end
            end
        end
    endtask

    task automatic check_outputs();
        check("rpt_val", 32'(bus.sig_rpt_val), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            check("rpt_len",  32'(bus.sig_rpt_len),  32'(mq[0].len));
            check("rpt_csum", 32'(bus.sig_rpt_csum), 32'(mq[0].csum));
            check("rpt_err",  32'(bus.sig_rpt_err),  32'(mq[0].err));
        end
        check("pkt_cnt",    32'(sig_pkt_cnt),    32'(m_pkt  & 255));
        check("err_cnt",    32'(sig_err_cnt),    32'(m_errc & 255));
        check("orphan_cnt", 32'(sig_orphan_cnt), 32'(m_orph & 255));
        check("drop_cnt",   32'(sig_drop_cnt),   32'(m_drop & 255));
        check("idle",       32'(sig_idle),       32'(!m_open && mq.size() == 0));
    endtask

    function automatic logic [255:0] rnd_data();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    // Drive one cycle of inputs just after an edge, advance the model, then
    // compare just after the edge that consumed them.
    task automatic step(input bit val, input bit sop, input bit eop,
                        input logic [7:0] vbc, input logic [255:0] data);
        bus.sig_i_val  = val;
        bus.sig_i_sop  = sop;
        bus.sig_i_eop  = eop;
        bus.sig_i_vbc  = vbc;
        bus.sig_i_data = data;
        model_beat(val, sop, eop, vbc, data, bus.sig_rpt_rdy);
        @(posedge sig_clock);
        #1;
        check_outputs();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'd0, rnd_data());
    endtask

    initial begin
        logic [255:0] d;
        int           e0, d0, o0;
        logic [7:0]   vbc;

        sig_reset       = 1'b1;
        bus.sig_i_val   = 1'b0;
        bus.sig_i_sop   = 1'b0;
        bus.sig_i_eop   = 1'b0;
        bus.sig_i_vbc   = 8'd0;
        bus.sig_i_data  = '0;
        bus.sig_rpt_rdy = 1'b1;
        model_reset();
        repeat (3) @(posedge sig_clock);
        #1;
        sig_reset = 1'b0;
        check("rst_len",  32'(bus.sig_rpt_len),  32'd0);
        check("rst_csum", 32'(bus.sig_rpt_csum), 32'd0);
        check("rst_err",  32'(bus.sig_rpt_err),  32'd0);
        check_outputs();

        // Single-beat packet, bytes 01..05 with junk above the valid count.
        d = rnd_data();
        d[39:0] = 40'h05_04_03_02_01;
        step(1'b1, 1'b1, 1'b1, 8'd5, d);
        check("single_val",  32'(bus.sig_rpt_val),  32'd1);
        check("single_len",  32'(bus.sig_rpt_len),  32'd5);
        check("single_csum", 32'(bus.sig_rpt_csum), 32'h01);
        check("single_err",  32'(bus.sig_rpt_err),  32'd0);
        check("single_pkt",  32'(sig_pkt_cnt),      32'd1);
        idle_cycles(1);

        // Three-beat packet 32/32/7, then a short middle beat.
        step(1'b1, 1'b1, 1'b0, 8'd32, rnd_data());
        step(1'b1, 1'b0, 1'b0, 8'd32, rnd_data());
        step(1'b1, 1'b0, 1'b1, 8'd7,  rnd_data());
        check("three_len", 32'(bus.sig_rpt_len), 32'd71);
        check("three_err", 32'(bus.sig_rpt_err), 32'd0);
        e0 = m_errc;
        step(1'b1, 1'b1, 1'b0, 8'd32, rnd_data());
        step(1'b1, 1'b0, 1'b0, 8'd20, rnd_data());
        step(1'b1, 1'b0, 1'b1, 8'd7,  rnd_data());
        check("short_err",  32'(bus.sig_rpt_err), 32'b0100);
        check("short_errc", 32'(sig_err_cnt),     32'(e0 + 1));
        idle_cycles(1);

        // sop mid-packet: one record, abort plus erroneous close count twice.
        e0 = m_errc;
        step(1'b1, 1'b1, 1'b0, 8'd32, rnd_data());
        step(1'b1, 1'b0, 1'b0, 8'd32, rnd_data());
        step(1'b1, 1'b1, 1'b1, 8'd3,  rnd_data());
        check("abort_len",  32'(bus.sig_rpt_len), 32'd3);
        check("abort_err",  32'(bus.sig_rpt_err), 32'b0001);
        check("abort_errc", 32'(sig_err_cnt),     32'(e0 + 2));
        idle_cycles(1);
        check("abort_one_rec", 32'(bus.sig_rpt_val), 32'd0);

        // Overfill with the consumer stalled, then drain in order.
        bus.sig_rpt_rdy = 1'b0;
        d0 = m_drop;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 8'($urandom_range(1, 32)), rnd_data());
        check("full_drop", 32'(sig_drop_cnt), 32'(d0 + 1));
        idle_cycles(2);
        bus.sig_rpt_rdy = 1'b1;
        idle_cycles(5);

        // Orphan beats in IDLE, with and without eop.
        o0 = m_orph;
        step(1'b1, 1'b0, 1'b0, 8'd32, rnd_data());
        step(1'b1, 1'b0, 1'b1, 8'd9,  rnd_data());
        check("orphan_cnt2", 32'(sig_orphan_cnt), 32'(o0 + 2));

        // Bad byte counts at both ends of the legal range.
        step(1'b1, 1'b1, 1'b0, 8'd0,  rnd_data());
        step(1'b1, 1'b0, 1'b0, 8'd33, rnd_data());
        step(1'b1, 1'b0, 1'b1, 8'd32, rnd_data());
        idle_cycles(1);

        // Length saturation: 2101 full beats overflow 16 bits.
        step(1'b1, 1'b1, 1'b0, 8'd32, rnd_data());
        for (int i = 0; i < 2099; i++) step(1'b1, 1'b0, 1'b0, 8'd32, rnd_data());
        step(1'b1, 1'b0, 1'b1, 8'd32, rnd_data());
        check("sat_len", 32'(bus.sig_rpt_len), 32'hffff);
        check("sat_err", 32'(bus.sig_rpt_err), 32'b1000);
        idle_cycles(1);

        // Back-to-back single-beat packets at full rate.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 8'($urandom_range(1, 32)), rnd_data());
        idle_cycles(1);

        // Reset in the middle of a packet with a record still queued.
        bus.sig_rpt_rdy = 1'b0;
        step(1'b1, 1'b1, 1'b1, 8'd4,  rnd_data());
        step(1'b1, 1'b1, 1'b0, 8'd32, rnd_data());
        step(1'b1, 1'b0, 1'b0, 8'd32, rnd_data());
        bus.sig_i_val = 1'b0;
        sig_reset = 1'b1;
        #2;
        model_reset();
        check("mid_rst_idle", 32'(sig_idle),    32'd1);
        check("mid_rst_pkt",  32'(sig_pkt_cnt), 32'd0);
        check_outputs();
        #2;
        sig_reset = 1'b0;
        bus.sig_rpt_rdy = 1'b1;
        idle_cycles(3);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: vbc = 8'd32;
                6, 7, 8:          vbc = 8'($urandom_range(1, 31));
                default:          vbc = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(33, 255));
            endcase
            bus.sig_rpt_rdy = ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 9) < 8, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0, vbc, rnd_data());
        end
        bus.sig_rpt_rdy = 1'b1;
        idle_cycles(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
